// File: rtl/text_console_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : text_console_ctrl
// Description : Character-cell text console controller. It accepts one
//               character per cycle, keeps a cursor, and writes character
//               codes into an external character RAM (row*COLS + col).
//               Handles CR, LF and BS. It clears the freshly entered line
//               after a line advance, and clears the whole screen on request.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               in_valid/in_char  - offered character
//               in_ready          - character accepted when in_valid&&in_ready
//               clr_req           - full-screen clear request
//               wr_en/wr_addr/
//               wr_data           - character RAM write port (registered)
//               cur_x/cur_y       - cursor column/row (registered)
//               busy              - a clear sequence is running
// Revision    : 1.0 - initial release
// ============================================================================
module text_console_ctrl #(
    parameter int         COLS  = 160,
    parameter int         ROWS  = 64,
    parameter logic [7:0] BLANK = 8'h20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_char,
    output logic        in_ready,
    input  logic        clr_req,
    output logic        wr_en,
    output logic [13:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic [7:0]  cur_x,
    output logic [6:0]  cur_y,
    output logic        busy
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_CLR_LINE = 2'd1;
    localparam logic [1:0] S_CLR_ALL  = 2'd2;

    localparam logic [13:0] c_cols     = 14'(COLS);
    localparam logic [13:0] c_cells    = 14'(ROWS * COLS);
    localparam logic [7:0]  c_last_col = 8'(COLS - 1);
    localparam logic [6:0]  c_last_row = 7'(ROWS - 1);

    logic [1:0]  r_state,   w_state;
    logic        r_wr_en,   w_wr_en;
    logic [13:0] r_wr_addr, w_wr_addr;
    logic [7:0]  r_wr_data, w_wr_data;
    logic [7:0]  r_cur_x,   w_cur_x;
    logic [6:0]  r_cur_y,   w_cur_y;
    // Clear progress counter and the base address of the region being cleared.
    logic [13:0] r_cnt,     w_cnt;
    logic [13:0] r_base,    w_base;

    logic [6:0]  w_next_y;
    logic [13:0] w_row_base;
    logic [13:0] w_next_base;
    logic        w_printable;
    logic        w_idle;

    assign w_idle      = (r_state == S_IDLE);
    assign w_next_y    = (r_cur_y == c_last_row) ? 7'd0 : r_cur_y + 7'd1;
    assign w_row_base  = 14'(r_cur_y) * c_cols;
    assign w_next_base = 14'(w_next_y) * c_cols;
    assign w_printable = (in_char >= 8'h20) && (in_char <= 8'h7E);

    assign in_ready = w_idle && !clr_req && !rst;
    assign busy     = !w_idle;
    assign wr_en    = r_wr_en;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign cur_x    = r_cur_x;
    assign cur_y    = r_cur_y;

    always_comb begin
        w_state   = r_state;
        w_wr_en   = 1'b0;
        w_wr_addr = r_wr_addr;
        w_wr_data = r_wr_data;
        w_cur_x   = r_cur_x;
        w_cur_y   = r_cur_y;
        w_cnt     = r_cnt;
        w_base    = r_base;

        case (r_state)
            S_IDLE: begin
                if (clr_req) begin
                    // The first blank write is issued right away, so the
                    // counter already points at the second cell.
                    w_state   = S_CLR_ALL;
                    w_wr_en   = 1'b1;
                    w_wr_addr = 14'd0;
                    w_wr_data = BLANK;
                    w_cur_x   = 8'd0;
                    w_cur_y   = 7'd0;
                    w_cnt     = 14'd1;
                end else if (in_valid) begin
                    if (w_printable) begin
                        w_wr_en   = 1'b1;
                        w_wr_addr = w_row_base + 14'(r_cur_x);
                        w_wr_data = in_char;
                        if (r_cur_x == c_last_col) begin
                            w_cur_x = 8'd0;
                            w_cur_y = w_next_y;
                            w_base  = w_next_base;
                            w_cnt   = 14'd0;
                            w_state = S_CLR_LINE;
                        end else begin
                            w_cur_x = r_cur_x + 8'd1;
                        end
                    end else if (in_char == 8'h0A) begin
                        w_cur_x = 8'd0;
                        w_cur_y = w_next_y;
                        w_base  = w_next_base;
                        w_cnt   = 14'd0;
                        w_state = S_CLR_LINE;
                    end else if (in_char == 8'h0D) begin
                        w_cur_x = 8'd0;
                    end else if ((in_char == 8'h08) && (r_cur_x != 8'd0)) begin
                        w_cur_x   = r_cur_x - 8'd1;
                        w_wr_en   = 1'b1;
                        w_wr_addr = w_row_base + 14'(r_cur_x - 8'd1);
                        w_wr_data = BLANK;
                    end
                end
            end

            S_CLR_LINE: begin
                // One extra pass with r_cnt == COLS returns to idle after the
                // last write has been presented.
                if (r_cnt < c_cols) begin
                    w_wr_en   = 1'b1;
                    w_wr_addr = r_base + r_cnt;
                    w_wr_data = BLANK;
                    w_cnt     = r_cnt + 14'd1;
                end else begin
                    w_state = S_IDLE;
                end
            end

            S_CLR_ALL: begin
                if (r_cnt < c_cells) begin
                    w_wr_en   = 1'b1;
                    w_wr_addr = r_cnt;
                    w_wr_data = BLANK;
                    w_cnt     = r_cnt + 14'd1;
                end else begin
                    w_state = S_IDLE;
                end
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_wr_en   <= 1'b0;
            r_wr_addr <= 14'd0;
            r_wr_data <= 8'd0;
            r_cur_x   <= 8'd0;
            r_cur_y   <= 7'd0;
            r_cnt     <= 14'd0;
            r_base    <= 14'd0;
        end else begin
            r_state   <= w_state;
            r_wr_en   <= w_wr_en;
            r_wr_addr <= w_wr_addr;
            r_wr_data <= w_wr_data;
            r_cur_x   <= w_cur_x;
            r_cur_y   <= w_cur_y;
            r_cnt     <= w_cnt;
            r_base    <= w_base;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_text_console_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_text_console_ctrl
// Description : Self-checking bench for text_console_ctrl (default params).
//               Table of single-cycle character vectors plus hand-written
//               sequences for line wrap, LF at the last row, BS, full clear
//               and reset during a clear.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_text_console_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_char;
    logic        in_ready;
    logic        clr_req;
    logic        wr_en;
    logic [13:0] wr_addr;
    logic [7:0]  wr_data;
    logic [7:0]  cur_x;
    logic [6:0]  cur_y;
    logic        busy;

    int errors = 0;
    int checks = 0;

    text_console_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_char  (in_char),
        .in_ready (in_ready),
        .clr_req  (clr_req),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cur_x    (cur_x),
        .cur_y    (cur_y),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [7:0]  ch;
        logic        exp_we;
        logic [13:0] exp_addr;
        logic [7:0]  exp_data;
        logic [7:0]  exp_x;
        logic [6:0]  exp_y;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Wait (bounded) for in_ready, then offer one character for one edge.
    // Returns #1 after the accepting edge.
    task automatic send(input logic [7:0] c);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", in_ready, 1);
        in_valid = 1'b1;
        in_char  = c;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Follows a clear of n cells starting at base, one write per cycle,
    // recording the first mismatch and how many cycles in_ready was low.
    task automatic track_clear(input string name, input int base, input int n,
                               input int pulse_at, output int lows);
        int bad;
        int first;
        bad   = 0;
        first = -1;
        lows  = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (clr_req) clr_req = 1'b0;
            if (!in_ready) lows++;
            if (wr_en !== 1'b1 || wr_addr !== 14'(base + i) || wr_data !== 8'h20 || busy !== 1'b1) begin
                if (first < 0) first = i;
                bad++;
            end
            if (i == pulse_at) clr_req = 1'b1;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s: %0d bad cycles, first at index %0d (got addr %0d, required %0d)",
                     name, bad, first, wr_addr, base + first);
        end
    endtask

    initial begin
        int lows;
        int stray;

        vecs[0]  = '{1'b1, 8'h41, 1'b1, 14'd0, 8'h41, 8'd1, 7'd0};
        vecs[1]  = '{1'b1, 8'h42, 1'b1, 14'd1, 8'h42, 8'd2, 7'd0};
        vecs[2]  = '{1'b1, 8'h0D, 1'b0, 14'd0, 8'h00, 8'd0, 7'd0};
        vecs[3]  = '{1'b1, 8'h07, 1'b0, 14'd0, 8'h00, 8'd0, 7'd0};
        vecs[4]  = '{1'b1, 8'h08, 1'b0, 14'd0, 8'h00, 8'd0, 7'd0};
        vecs[5]  = '{1'b1, 8'h78, 1'b1, 14'd0, 8'h78, 8'd1, 7'd0};
        vecs[6]  = '{1'b1, 8'h79, 1'b1, 14'd1, 8'h79, 8'd2, 7'd0};
        vecs[7]  = '{1'b1, 8'h08, 1'b1, 14'd1, 8'h20, 8'd1, 7'd0};
        vecs[8]  = '{1'b1, 8'h7F, 1'b0, 14'd0, 8'h00, 8'd1, 7'd0};
        vecs[9]  = '{1'b1, 8'h1F, 1'b0, 14'd0, 8'h00, 8'd1, 7'd0};
        vecs[10] = '{1'b1, 8'h20, 1'b1, 14'd1, 8'h20, 8'd2, 7'd0};
        vecs[11] = '{1'b1, 8'h7E, 1'b1, 14'd2, 8'h7E, 8'd3, 7'd0};
        vecs[12] = '{1'b0, 8'h41, 1'b0, 14'd0, 8'h00, 8'd3, 7'd0};
        vecs[13] = '{1'b1, 8'h0D, 1'b0, 14'd0, 8'h00, 8'd0, 7'd0};

        rst      = 1'b1;
        in_valid = 1'b0;
        in_char  = 8'h00;
        clr_req  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_wr_en",    wr_en,    0);
        chk("rst_wr_addr",  wr_addr,  0);
        chk("rst_wr_data",  wr_data,  0);
        chk("rst_cur_x",    cur_x,    0);
        chk("rst_cur_y",    cur_y,    0);
        chk("rst_busy",     busy,     0);
        @(negedge clk);
        rst = 1'b0;

        // Single-cycle character table
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            in_valid = vecs[k].v;
            in_char  = vecs[k].ch;
            #1;
            chk($sformatf("v%0d_in_ready", k), in_ready, 1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            chk($sformatf("v%0d_wr_en", k), wr_en, vecs[k].exp_we);
            if (vecs[k].exp_we) begin
                chk($sformatf("v%0d_wr_addr", k), wr_addr, vecs[k].exp_addr);
                chk($sformatf("v%0d_wr_data", k), wr_data, vecs[k].exp_data);
            end
            chk($sformatf("v%0d_cur_x", k), cur_x, vecs[k].exp_x);
            chk($sformatf("v%0d_cur_y", k), cur_y, vecs[k].exp_y);
            chk($sformatf("v%0d_busy", k), busy, 0);
        end

        // Wrap at the last column: cursor (159,5)
        for (int k = 0; k < 5; k++) send(8'h0A);
        for (int k = 0; k < 159; k++) send(8'h61);
        chk("pre_wrap_x", cur_x, 159);
        chk("pre_wrap_y", cur_y, 5);
        send(8'h42);
        chk("wrap_wr_en",   wr_en,   1);
        chk("wrap_wr_addr", wr_addr, 959);
        chk("wrap_wr_data", wr_data, 8'h42);
        chk("wrap_cur_x",   cur_x,   0);
        chk("wrap_cur_y",   cur_y,   6);
        chk("wrap_busy",    busy,    1);
        track_clear("wrap_line_clear", 960, 160, -1, lows);
        lows = lows + (in_ready ? 0 : 0);
        @(posedge clk);
        #1;
        chk("wrap_done_wr_en",    wr_en,    0);
        chk("wrap_done_in_ready", in_ready, 1);
        chk("wrap_done_busy",     busy,     0);
        chk("wrap_ready_low_cycles", lows + 1, 161);

        // LF on the last row wraps to row 0; clr_req during CLR_LINE is ignored
        for (int k = 0; k < 57; k++) send(8'h0A);
        for (int k = 0; k < 10; k++) send(8'h63);
        chk("pre_lf_x", cur_x, 10);
        chk("pre_lf_y", cur_y, 63);
        send(8'h0A);
        chk("lf_wr_en", wr_en, 0);
        chk("lf_cur_x", cur_x, 0);
        chk("lf_cur_y", cur_y, 0);
        track_clear("lf_line_clear", 0, 160, 50, lows);
        @(posedge clk);
        #1;
        chk("lf_done_wr_en", wr_en, 0);
        chk("lf_done_busy",  busy,  0);
        repeat (3) @(posedge clk);
        #1;
        chk("lf_no_queued_clear", wr_en | busy, 0);

        // Backspace at column 0 and at column 4 on row 3
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) send(8'h0A);
        send(8'h08);
        chk("bs0_wr_en", wr_en, 0);
        chk("bs0_cur_x", cur_x, 0);
        chk("bs0_cur_y", cur_y, 3);
        for (int k = 0; k < 4; k++) send(8'h64);
        send(8'h08);
        chk("bs4_wr_en",   wr_en,   1);
        chk("bs4_wr_addr", wr_addr, 483);
        chk("bs4_wr_data", wr_data, 8'h20);
        chk("bs4_cur_x",   cur_x,   3);
        chk("bs4_cur_y",   cur_y,   3);

        // clr_req and in_valid together: clear wins
        @(negedge clk);
        in_valid = 1'b1;
        in_char  = 8'h5A;
        clr_req  = 1'b1;
        #1;
        chk("clr_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clr_req  = 1'b0;
        chk("clr_first_wr_en",   wr_en,   1);
        chk("clr_first_wr_addr", wr_addr, 0);
        chk("clr_first_wr_data", wr_data, 8'h20);
        chk("clr_cur_x", cur_x, 0);
        chk("clr_cur_y", cur_y, 0);
        chk("clr_busy",  busy,  1);
        track_clear("clr_all_seq", 1, 10239, -1, lows);
        @(posedge clk);
        #1;
        chk("clr_done_wr_en",    wr_en,    0);
        chk("clr_done_busy",     busy,     0);
        chk("clr_done_in_ready", in_ready, 1);

        // Reset after 500 CLR_ALL writes
        @(negedge clk);
        send(8'h65);
        @(negedge clk);
        clr_req = 1'b1;
        @(posedge clk);
        #1;
        clr_req = 1'b0;
        track_clear("abort_prefix", 1, 499, -1, lows);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_in_ready_rst", in_ready, 0);
        @(posedge clk);
        #1;
        chk("abort_wr_en",   wr_en,   0);
        chk("abort_busy",    busy,    0);
        chk("abort_cur_x",   cur_x,   0);
        chk("abort_cur_y",   cur_y,   0);
        chk("abort_wr_addr", wr_addr, 0);
        @(negedge clk);
        chk("abort_in_ready_held", in_ready, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_in_ready_after", in_ready, 1);
        stray = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (wr_en || busy) stray++;
        end
        chk("abort_no_restart", stray, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #2000000;
        errors++;
        $display("FAIL timeout: simulation did not complete, got running required finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
